qbus_master: RTL and testbench

Parametrised QBUS bus-master cycle sequencer: accepts one transfer request per handshake and runs a complete DATI, DATO, DATOB or (optionally) DATIO cycle on the bus. It drives the FPGA side of the qdrv transceivers (ZDAL/ZBS7/ZWTBT, DALbe_L/DALtx/DALst, TSYNC/TDIN/TDOUT) and times out on missing RPLY, reporting a non-existent-memory (NXM) error. It sits between the DMA engine and qdrv, after external bus arbitration has granted mastership.

---
 rtl/qbus_master.sv | 260 ++++++++++++++++++++++++++
 tb/tb_qbus_master.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/qbus_master.sv
// QBUS bus-master cycle sequencer: runs DATI/DATO/DATOB cycles on the qdrv transceivers.
// Define QBUS_MASTER_RMW_EN to add DATIO (read-modify-write under a single TSYNC).
`timescale 1ns/1ps
module qbus_master #(
    parameter int AW         = 22,
    parameter int ADDR_SETUP = 3,
    parameter int ADDR_HOLD  = 2,
    parameter int DATA_SETUP = 2,
    parameter int DESKEW     = 3,
    parameter int NXM_CYCLES = 200
) (
    input  logic          qclk,
    input  logic          reset,
    input  logic          grant,
    input  logic          req,
    input  logic          write,
    input  logic          byte_sel,
    input  logic          rmw,
    input  logic          iopage,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic          busy,
    output logic          done,
    output logic          nxm,
    output logic [15:0]   rdata,
    inout  wire  [21:0]   ZDAL,
    output wire           ZBS7,
    output wire           ZWTBT,
    output logic          DALbe_L,
    output logic          DALtx,
    output logic          DALst,
    input  logic          RRPLY,
    output logic          TSYNC,
    output logic          TDIN,
    output logic          TDOUT
);

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int SMAX = imax(imax(ADDR_SETUP, ADDR_HOLD), imax(DATA_SETUP, DESKEW));
    localparam int CW   = imax($clog2(NXM_CYCLES + 1), $clog2(SMAX + 1));

    localparam logic [CW-1:0] ASU_LAST = CW'(ADDR_SETUP - 1);
    localparam logic [CW-1:0] AHD_LAST = CW'(ADDR_HOLD - 1);
    localparam logic [CW-1:0] DSU_LAST = CW'(DATA_SETUP - 1);
    localparam logic [CW-1:0] DSK_LAST = CW'(DESKEW - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(NXM_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, SYNC, DIN, DSKW, DINEND, WSET, DOUT, DOUTEND, END
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt;
    logic          rply_meta, rply_s;
    logic          rel_q;
    logic          nxm_q;

    logic [21:0]   addr_q;
    logic [15:0]   wdata_q;
    logic          write_q, byte_q, iopage_q, rmw_q;

    logic          accept, capture, set_nxm, timeout;
    logic          zdal_oe, bs7_oe, wtbt_oe, wtbt_val;
    logic [21:0]   zdal_val;

    // RRPLY is asynchronous to qclk; only rply_s may steer the sequencer.
    always_ff @(posedge qclk) begin
        if (reset) begin
            rply_meta <= 1'b0;
            rply_s    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            rply_meta <= RRPLY;
            rply_s    <= rply_meta;
        end
    end

    always_ff @(posedge qclk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            rel_q <= 1'b0;
            nxm_q <= 1'b0;
            rdata <= '0;
        end else begin
            state <= state_next;
            cnt   <= (state_next != state) ? '0 : cnt + 1'b1;
            rel_q <= (state == DOUTEND) && (rel_q || !rply_s);
            if (accept)
                nxm_q <= 1'b0;
            else if (set_nxm)
                nxm_q <= 1'b1;
            if (capture)
                rdata <= ZDAL[15:0];
        end
    end

    // NOTE: request holding registers carry no reset; they are only read after a load on accept.
    always_ff @(posedge qclk) begin
        if (accept) begin
            addr_q   <= 22'(addr);
            wdata_q  <= wdata;
            write_q  <= write;
            byte_q   <= byte_sel;
            iopage_q <= iopage;
        end
    end

`ifdef QBUS_MASTER_RMW_EN
    always_ff @(posedge qclk) begin
        if (accept)
            rmw_q <= rmw;
    end
`else
    logic unused_rmw;
    assign unused_rmw = rmw;
    assign rmw_q      = 1'b0;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next = state;
        accept     = 1'b0;
        capture    = 1'b0;
        set_nxm    = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        TSYNC      = 1'b0;
        TDIN       = 1'b0;
        TDOUT      = 1'b0;
        DALtx      = 1'b0;
        DALbe_L    = 1'b1;
        DALst      = 1'b0;
        zdal_oe    = 1'b0;
        zdal_val   = addr_q;
        bs7_oe     = 1'b0;
        wtbt_oe    = 1'b0;
        wtbt_val   = write_q;
        timeout    = (cnt == TO_LAST);

        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (req && grant) begin
                    accept     = 1'b1;
                    state_next = ADDR;
                end
            end
            ADDR: begin
                zdal_oe = 1'b1;
                bs7_oe  = 1'b1;
                wtbt_oe = 1'b1;
                DALtx   = 1'b1;
                DALbe_L = 1'b0;
                DALst   = (cnt == '0);
                if (cnt == ASU_LAST)
                    state_next = SYNC;
            end
            SYNC: begin
                TSYNC   = 1'b1;
                zdal_oe = 1'b1;
                bs7_oe  = 1'b1;
                wtbt_oe = 1'b1;
                DALtx   = 1'b1;
                DALbe_L = 1'b0;
                if (cnt == AHD_LAST)
                    state_next = (write_q && !rmw_q) ? WSET : DIN;
            end
            DIN: begin
                TSYNC = 1'b1;
                TDIN  = 1'b1;
                if (rply_s) begin
                    state_next = DSKW;
                end else if (timeout) begin
                    set_nxm    = 1'b1;
                    state_next = END;
                end
            end
            DSKW: begin
                TSYNC = 1'b1;
                TDIN  = 1'b1;
                if (cnt == DSK_LAST) begin
                    capture    = 1'b1;
                    state_next = DINEND;
                end
            end
            DINEND: begin
                TSYNC = 1'b1;
                if (!rply_s) begin
                    state_next = rmw_q ? WSET : END;
                end else if (timeout) begin
                    set_nxm    = 1'b1;
                    state_next = END;
                end
            end
            WSET: begin
                TSYNC    = 1'b1;
                zdal_oe  = 1'b1;
                zdal_val = {6'b0, wdata_q};
                wtbt_oe  = 1'b1;
                wtbt_val = byte_q;
                DALtx    = 1'b1;
                DALbe_L  = 1'b0;
                DALst    = (cnt == '0);
                if (cnt == DSU_LAST)
                    state_next = DOUT;
            end
            DOUT: begin
                TSYNC    = 1'b1;
                TDOUT    = 1'b1;
                zdal_oe  = 1'b1;
                zdal_val = {6'b0, wdata_q};
                wtbt_oe  = 1'b1;
                wtbt_val = byte_q;
                DALtx    = 1'b1;
                DALbe_L  = 1'b0;
                if (rply_s) begin
                    state_next = DOUTEND;
                end else if (timeout) begin
                    set_nxm    = 1'b1;
                    state_next = END;
                end
            end
            DOUTEND: begin
                // Data stays on the bus one cycle past RPLY negation (rel_q).
                TSYNC    = 1'b1;
                zdal_oe  = 1'b1;
                zdal_val = {6'b0, wdata_q};
                wtbt_oe  = 1'b1;
                wtbt_val = byte_q;
                DALtx    = 1'b1;
                DALbe_L  = 1'b0;
                if (rel_q) begin
                    state_next = END;
                end else if (timeout) begin
                    set_nxm    = 1'b1;
                    state_next = END;
                end
            end
            END: begin
                busy       = 1'b0;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign nxm   = nxm_q;
    assign ZDAL  = zdal_oe ? zdal_val : 22'bz;
    assign ZBS7  = bs7_oe  ? iopage_q : 1'bz;
    assign ZWTBT = wtbt_oe ? wtbt_val : 1'bz;

    logic [5:0] unused_zdal_hi;
    assign unused_zdal_hi = ZDAL[21:16];

endmodule

// File: tb/tb_qbus_master.sv
// Directed bench for qbus_master: a behavioural QBUS slave with a small word memory
// answers DIN/DOUT; expected values are hand-computed octal constants.
`timescale 1ns/1ps
module tb_qbus_master;

    localparam int ADDR_SETUP = 3;
    localparam int NXM_CYCLES = 200;
    localparam int RPLY_DLY   = 6;
`ifdef QBUS_MASTER_RMW_EN
    localparam bit RMW = 1'b1;
`else
    localparam bit RMW = 1'b0;
`endif

    logic        qclk = 1'b0;
    logic        reset = 1'b1;
    logic        grant = 1'b0;
    logic        req = 1'b0;
    logic        write = 1'b0;
    logic        byte_sel = 1'b0;
    logic        rmw = 1'b0;
    logic        iopage = 1'b0;
    logic [21:0] addr = '0;
    logic [15:0] wdata = '0;
    logic        busy, done, nxm;
    logic [15:0] rdata;
    wire  [21:0] zdal_bus;
    wire         ZBS7, ZWTBT;
    logic        DALbe_L, DALtx, DALst;
    logic        RRPLY = 1'b0;
    logic        TSYNC, TDIN, TDOUT;

    logic        slave_oe = 1'b0;
    logic [15:0] slave_val = '0;
    logic        probe_oe = 1'b0;
    assign zdal_bus = (slave_oe || probe_oe) ? (slave_oe ? {6'b0, slave_val} : 22'h0) : 22'bz;

    qbus_master #(
        .AW(22), .ADDR_SETUP(ADDR_SETUP), .ADDR_HOLD(2), .DATA_SETUP(2),
        .DESKEW(3), .NXM_CYCLES(NXM_CYCLES)
    ) dut (
        .qclk(qclk), .reset(reset), .grant(grant), .req(req), .write(write),
        .byte_sel(byte_sel), .rmw(rmw), .iopage(iopage), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .nxm(nxm), .rdata(rdata), .ZDAL(zdal_bus),
        .ZBS7(ZBS7), .ZWTBT(ZWTBT), .DALbe_L(DALbe_L), .DALtx(DALtx), .DALst(DALst),
        .RRPLY(RRPLY), .TSYNC(TSYNC), .TDIN(TDIN), .TDOUT(TDOUT)
    );

    always #25 qclk = ~qclk;

    int cyc = 0;
    initial forever @(posedge qclk) cyc++;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0o, expected %0o (octal)", tag, got, exp);
        end
    endtask

    // Bus activity observed at negedges; cleared at the start of each request.
    int req_cyc, tsync_cyc, tsync_rises, tdout_fall_cyc, done_cyc;
    int tdin_cnt, tdout_cnt, dalst_cnt, done_cnt;
    int rply_rise_cyc, rply_fall_cyc;
    logic tsync_d = 1'b0, tdout_d = 1'b0;

    initial begin
        forever begin
            @(negedge qclk);
            if (TSYNC && !tsync_d) begin
                tsync_rises++;
                if (tsync_cyc < 0) tsync_cyc = cyc;
            end
            if (!TDOUT && tdout_d) tdout_fall_cyc = cyc;
            if (TDIN)  tdin_cnt++;
            if (TDOUT) tdout_cnt++;
            if (DALst) dalst_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            tsync_d = TSYNC;
            tdout_d = TDOUT;
        end
    end

    // Behavioural slave: replies RPLY_DLY cycles after TDIN/TDOUT.
    logic [15:0] mem [int];
    logic        slave_on = 1'b1;
    logic [21:0] s_addr = '0;
    logic        s_bs7 = 1'b0, s_wtbt_a = 1'b0, s_wtbt_d = 1'b0, s_tsync_d = 1'b0;
    int          s_st = 0, s_cnt = 0;

    initial begin
        forever begin
            @(negedge qclk);
            if (TSYNC && !s_tsync_d) begin
                s_addr   = zdal_bus;
                s_bs7    = ZBS7;
                s_wtbt_a = ZWTBT;
            end
            s_tsync_d = TSYNC;
            case (s_st)
                0: if (slave_on && TDIN) begin
                       s_cnt = 1; s_st = 1;
                   end else if (slave_on && TDOUT) begin
                       s_cnt = 1; s_st = 3;
                   end
                1: if (s_cnt >= RPLY_DLY) begin
                       slave_val = mem[int'(s_addr >> 1)];
                       slave_oe = 1'b1; RRPLY = 1'b1; rply_rise_cyc = cyc; s_st = 2;
                   end else s_cnt++;
                2: if (!TDIN) begin
                       RRPLY = 1'b0; slave_oe = 1'b0; rply_fall_cyc = cyc; s_st = 0;
                   end
                3: if (s_cnt >= RPLY_DLY) begin
                       s_wtbt_d = ZWTBT;
                       if (!ZWTBT)
                           mem[int'(s_addr >> 1)] = zdal_bus[15:0];
                       else if (s_addr[0])
                           mem[int'(s_addr >> 1)][15:8] = zdal_bus[15:8];
                       else
                           mem[int'(s_addr >> 1)][7:0] = zdal_bus[7:0];
                       RRPLY = 1'b1; rply_rise_cyc = cyc; s_st = 4;
                   end else s_cnt++;
                4: if (!TDOUT) begin
                       RRPLY = 1'b0; rply_fall_cyc = cyc; s_st = 0;
                   end
                default: s_st = 0;
            endcase
        end
    end

    task automatic start_req(input logic w, input logic b, input logic r, input logic io,
                             input logic [21:0] a, input logic [15:0] wd);
        @(negedge qclk);
        tsync_cyc = -1; tsync_rises = 0; tdout_fall_cyc = -1; done_cyc = -1;
        tdin_cnt = 0; tdout_cnt = 0; dalst_cnt = 0; done_cnt = 0;
        rply_rise_cyc = -1; rply_fall_cyc = -1; s_wtbt_d = 1'b0;
        write = w; byte_sel = b; rmw = r; iopage = io; addr = a; wdata = wd;
        grant = 1'b1; req = 1'b1;
        req_cyc = cyc;
        @(negedge qclk);
        req = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge qclk);
            n++;
        end
        check("done_seen", done, 1'b1);
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge qclk);
    endtask

    task automatic run_cycle(input logic w, input logic b, input logic r, input logic io,
                             input logic [21:0] a, input logic [15:0] wd);
        start_req(w, b, r, io, a, wd);
        wait_done(400);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mem[int'(22'o777570 >> 1)] = 16'o177777;
        mem[int'(22'o560 >> 1)]    = 16'o123456;

        repeat (3) @(negedge qclk);
        check("rst_ctrl", {TSYNC, TDIN, TDOUT, DALtx, DALst, busy, done, nxm, DALbe_L}, 9'b000000001);
        check("rst_rdata", rdata, 16'o0);
        probe_oe = 1'b1; #1;
        check("rst_zdal_float", zdal_bus, 22'o0);
        probe_oe = 1'b0;
        reset = 1'b0;

        // Request without grant is never accepted.
        req = 1'b1; grant = 1'b0;
        settle(3);
        check("no_grant_idle", {busy, TSYNC}, 2'b00);
        req = 1'b0;

        // DATI from the I/O page.
        run_cycle(1'b0, 1'b0, 1'b0, 1'b1, 22'o777570, 16'o0);
        check("dati_rdata", rdata, 16'o177777);
        check("dati_nxm", nxm, 1'b0);
        settle(2);
        check("dati_tsync_delay", tsync_cyc - req_cyc, ADDR_SETUP + 1);
        check("dati_slave_addr", s_addr, 22'o777570);
        check("dati_bs7", s_bs7, 1'b1);
        check("dati_done_after_rply", done_cyc - rply_fall_cyc, 3);
        check("dati_done_pulses", done_cnt, 1);
        check("dati_dalst", dalst_cnt, 1);
        check("dati_idle", busy, 1'b0);

        // DATI to non-existent memory.
        slave_on = 1'b0;
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 22'o17000000, 16'o0);
        check("nxm_flag", nxm, 1'b1);
        check("nxm_tsync", TSYNC, 1'b0);
        probe_oe = 1'b1; #1;
        check("nxm_zdal_float", zdal_bus, 22'o0);
        probe_oe = 1'b0;
        settle(2);
        check("nxm_tdin_cycles", tdin_cnt, NXM_CYCLES);
        check("nxm_done_pulses", done_cnt, 1);
        slave_on = 1'b1;

        // DATO; grant drops after acceptance and the cycle still completes.
        start_req(1'b1, 1'b0, 1'b0, 1'b0, 22'o440, 16'o054321);
        grant = 1'b0;
        wait_done(400);
        check("dato_nxm", nxm, 1'b0);
        settle(2);
        grant = 1'b1;
        check("dato_tdout_drop", tdout_fall_cyc - rply_rise_cyc, 3);
        check("dato_done_after_rply", done_cyc - rply_fall_cyc, 4);
        check("dato_dalst", dalst_cnt, 2);
        check("dato_wtbt_data", s_wtbt_d, 1'b0);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 22'o440, 16'o0);
        check("dato_readback", rdata, 16'o054321);
        settle(1);

        // DATOB to the odd byte: only the high byte changes.
        run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 22'o441, 16'o000252);
        settle(2);
        check("datob_wtbt_addr", s_wtbt_a, 1'b1);
        check("datob_wtbt_data", s_wtbt_d, 1'b1);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 22'o440, 16'o0);
        check("datob_readback", rdata, 16'o000321);
        settle(1);

        // DATIO (plain DATI when the RMW option is absent).
        run_cycle(1'b0, 1'b0, 1'b1, 1'b0, 22'o560, 16'o054545);
        check("datio_rdata", rdata, 16'o123456);
        settle(2);
        check("datio_one_tsync", tsync_rises, 1);
        check("datio_tdout_seen", tdout_cnt != 0, RMW);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 22'o560, 16'o0);
        check("datio_readback", rdata, RMW ? 16'o054545 : 16'o123456);
        settle(1);

        // Reset while waiting for RPLY in DIN.
        slave_on = 1'b0;
        start_req(1'b0, 1'b0, 1'b0, 1'b0, 22'o1000, 16'o0);
        for (int i = 0; i < 20 && !TDIN; i++) @(negedge qclk);
        check("rst_mid_din_reached", TDIN, 1'b1);
        reset = 1'b1;
        @(posedge qclk); #1;
        check("rst_mid_ctrl", {TSYNC, TDIN, TDOUT, DALtx, busy, DALbe_L}, 6'b000001);
        check("rst_mid_rdata", rdata, 16'o0);
        @(negedge qclk);
        reset = 1'b0;
        slave_on = 1'b1;
        settle(3);
        check("rst_mid_no_done", done_cnt, 0);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b1, 22'o777570, 16'o0);
        check("rst_mid_after_rdata", rdata, 16'o177777);
        check("rst_mid_after_nxm", nxm, 1'b0);
        settle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
